// File: rtl/delay_line_if.sv
// Stream, configuration and status signals of the programmable delay line.
// The master modport drives samples and configuration; the slave modport is the delay line.
interface delay_line_if #(
  parameter int G_DATA_WIDTH = 32,
  parameter int G_MAX_DELAY  = 16,
  parameter int G_DELAY_W    = $clog2(G_MAX_DELAY + 1)
);

  logic [G_DATA_WIDTH-1:0] data_in;
  logic                    data_in_valid;
  logic [G_DELAY_W-1:0]    cfg_delay;
  logic                    cfg_load;
  logic [G_DATA_WIDTH-1:0] delayed_data;
  logic                    delayed_data_valid;
  logic [G_DELAY_W-1:0]    cur_delay;
  logic [G_DELAY_W-1:0]    in_flight;
  logic                    cfg_err;

  modport master (
    output data_in, data_in_valid, cfg_delay, cfg_load,
    input  delayed_data, delayed_data_valid, cur_delay, in_flight, cfg_err
  );

  modport slave (
    input  data_in, data_in_valid, cfg_delay, cfg_load,
    output delayed_data, delayed_data_valid, cur_delay, in_flight, cfg_err
  );

endinterface

// File: rtl/delay_line.sv
// Programmable delay line: each valid sample reappears exactly D cycles later,
// D = 1..G_MAX_DELAY, with up to D samples in flight. A legal reconfiguration
// flushes everything in flight; an illegal one is rejected with a cfg_err pulse.
//
// The G_MAX_DELAY stages are G_MAX_DELAY-1 shift stages plus the output register.
// The output register taps the live input for D=1, else shift stage D-2.
module delay_line #(
  parameter int G_DATA_WIDTH  = 32,
  parameter int G_MAX_DELAY   = 16,
  parameter int G_RESET_DELAY = 3,
  parameter int G_DELAY_W     = $clog2(G_MAX_DELAY + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  delay_line_if.slave  bus
);

  // Keep at least one shift stage so G_MAX_DELAY=1 still elaborates; it is never tapped then.
  localparam int P_DEPTH = (G_MAX_DELAY > 1) ? G_MAX_DELAY - 1 : 1;

  logic [P_DEPTH-1:0]      stage_valid_q, stage_valid_d;
  logic [G_DATA_WIDTH-1:0] stage_data_q [P_DEPTH];
  logic [G_DATA_WIDTH-1:0] stage_data_d [P_DEPTH];
  logic [G_DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic [G_DELAY_W-1:0]    cur_delay_q, cur_delay_d;
  logic [G_DELAY_W-1:0]    in_flight_q, in_flight_d;
  logic                    cfg_err_q, cfg_err_d;

  logic                    cfg_legal;
  logic                    flush;
  logic                    tap_valid;
  logic [G_DATA_WIDTH-1:0] tap_data;

  // Select the pipeline tap matching the active delay.
  always_comb begin
    tap_valid = bus.data_in_valid;
    tap_data  = bus.data_in;
    for (int i = 0; i < P_DEPTH; i++) begin
      if (int'(cur_delay_q) == i + 2) begin
        tap_valid = stage_valid_q[i];
        tap_data  = stage_data_q[i];
      end
    end
  end

  // Next-state logic: shift, configuration, output selection and occupancy count.
  always_comb begin
    cfg_legal = (bus.cfg_delay != '0) && (int'(bus.cfg_delay) <= G_MAX_DELAY);
    flush     = bus.cfg_load && cfg_legal;

    // The sample arriving with a legal load enters stage 0 and runs under the new delay.
    stage_valid_d    = '0;
    stage_valid_d[0] = bus.data_in_valid;
    stage_data_d[0]  = bus.data_in;
    for (int i = 1; i < P_DEPTH; i++) begin
      stage_valid_d[i] = stage_valid_q[i-1] && !flush;
      stage_data_d[i]  = stage_data_q[i-1];
    end

    // On a flush only a new D=1 sample may emerge next cycle; the old tap is discarded.
    out_valid_d = tap_valid;
    out_data_d  = out_data_q;
    if (flush) begin
      out_valid_d = (bus.cfg_delay == G_DELAY_W'(1)) && bus.data_in_valid;
      if (out_valid_d) out_data_d = bus.data_in;
    end else if (tap_valid) begin
      out_data_d = tap_data;
    end

    cur_delay_d = flush ? bus.cfg_delay : cur_delay_q;
    cfg_err_d   = bus.cfg_load && !cfg_legal;

    // A sample counts as in flight up to and including the cycle its pulse is shown.
    if (flush) begin
      in_flight_d = G_DELAY_W'(bus.data_in_valid);
    end else begin
      in_flight_d = in_flight_q + G_DELAY_W'(bus.data_in_valid) - G_DELAY_W'(out_valid_q);
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid_q <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      cur_delay_q   <= G_DELAY_W'(G_RESET_DELAY);
      in_flight_q   <= '0;
      cfg_err_q     <= 1'b0;
    end else begin
      stage_valid_q <= stage_valid_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      cur_delay_q   <= cur_delay_d;
      in_flight_q   <= in_flight_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  // Stage data is qualified by the valid bits, so it carries no reset.
  always_ff @(posedge clk) begin
    stage_data_q <= stage_data_d;
  end

  assign bus.delayed_data       = out_data_q;
  assign bus.delayed_data_valid = out_valid_q;
  assign bus.cur_delay          = cur_delay_q;
  assign bus.in_flight          = in_flight_q;
  assign bus.cfg_err            = cfg_err_q;

endmodule

// File: tb/tb_delay_line.sv
// Bench for delay_line: a negedge scoreboard predicts every output pulse and
// status value, a vector table exercises rejected configurations, and directed
// sequences cover flush, D=1 streaming and mid-operation reset.
module tb_delay_line;

  localparam int DW = 32;
  localparam int MD = 16;
  localparam int W  = $clog2(MD + 1);
  localparam int RD = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  delay_line_if #(.G_DATA_WIDTH(DW), .G_MAX_DELAY(MD)) dif ();

  delay_line #(
    .G_DATA_WIDTH (DW),
    .G_MAX_DELAY  (MD),
    .G_RESET_DELAY(RD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dif)
  );

  typedef struct {
    int              due;
    logic [DW-1:0]   data;
  } exp_t;

  typedef struct {
    logic            load;
    logic [W-1:0]    dly;
    logic            vin;
    logic [DW-1:0]   din;
    logic            exp_err;
    logic [W-1:0]    exp_cur;
  } cfg_vec_t;

  exp_t          sb[$];
  int            n_chk  = 0;
  int            n_fail = 0;
  int            n_pulse = 0;
  int            peak = 0;
  logic [W-1:0]  m_delay = W'(RD);
  logic          m_err = 1'b0;
  logic [DW-1:0] m_last = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: check this cycle's outputs, then fold in this cycle's inputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_delay = W'(RD);
      m_err   = 1'b0;
      m_last  = '0;
      chk("rst_valid", 64'(dif.delayed_data_valid), 64'd0);
      chk("rst_data", 64'(dif.delayed_data), 64'd0);
      chk("rst_in_flight", 64'(dif.in_flight), 64'd0);
      chk("rst_cur_delay", 64'(dif.cur_delay), 64'(RD));
      chk("rst_cfg_err", 64'(dif.cfg_err), 64'd0);
    end else begin
      logic exp_v;
      if (int'(dif.in_flight) > peak) peak = int'(dif.in_flight);
      if (dif.delayed_data_valid) n_pulse++;
      chk("in_flight", 64'(dif.in_flight), 64'(sb.size()));
      chk("cur_delay", 64'(dif.cur_delay), 64'(m_delay));
      chk("cfg_err", 64'(dif.cfg_err), 64'(m_err));
      exp_v = (sb.size() > 0) && (sb[0].due == cyc);
      chk("valid", 64'(dif.delayed_data_valid), 64'(exp_v));
      if (exp_v) begin
        m_last = sb[0].data;
        void'(sb.pop_front());
      end
      chk("data", 64'(dif.delayed_data), 64'(m_last));
      m_err = 1'b0;
      if (dif.cfg_load) begin
        if (dif.cfg_delay != '0 && int'(dif.cfg_delay) <= MD) begin
          sb.delete();
          m_delay = dif.cfg_delay;
        end else begin
          m_err = 1'b1;
        end
      end
      if (dif.data_in_valid) sb.push_back('{due: cyc + int'(m_delay), data: dif.data_in});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic ld, input logic [W-1:0] dl);
    dif.data_in_valid = v;
    dif.data_in       = d;
    dif.cfg_load      = ld;
    dif.cfg_delay     = dl;
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, 1'b0, '0);
    repeat (n) tick();
  endtask

  cfg_vec_t vec[6];

  initial begin
    logic [7:0] pat;
    int         p0;

    // Rejected loads around two in-flight samples at D=3.
    vec[0] = '{load: 1'b0, dly: 5'd0,  vin: 1'b1, din: 32'hA1, exp_err: 1'b0, exp_cur: 5'd3};
    vec[1] = '{load: 1'b1, dly: 5'd0,  vin: 1'b1, din: 32'hA2, exp_err: 1'b1, exp_cur: 5'd3};
    vec[2] = '{load: 1'b1, dly: 5'd17, vin: 1'b0, din: 32'h0,  exp_err: 1'b1, exp_cur: 5'd3};
    vec[3] = '{load: 1'b0, dly: 5'd0,  vin: 1'b0, din: 32'h0,  exp_err: 1'b0, exp_cur: 5'd3};
    vec[4] = '{load: 1'b0, dly: 5'd0,  vin: 1'b0, din: 32'h0,  exp_err: 1'b0, exp_cur: 5'd3};
    vec[5] = '{load: 1'b0, dly: 5'd0,  vin: 1'b0, din: 32'h0,  exp_err: 1'b0, exp_cur: 5'd3};

    drive(1'b0, '0, 1'b0, '0);
    repeat (3) tick();
    rst_n = 1'b1;

    // Single sample at reset delay.
    idle(9);
    drive(1'b1, 32'hDEADBEEF, 1'b0, '0);
    tick();
    idle(6);

    // Rejected configurations, table driven.
    for (int i = 0; i < 6; i++) begin
      drive(vec[i].vin, vec[i].din, vec[i].load, vec[i].dly);
      tick();
      chk("tbl_cfg_err", 64'(dif.cfg_err), 64'(vec[i].exp_err));
      chk("tbl_cur_delay", 64'(dif.cur_delay), 64'(vec[i].exp_cur));
    end
    idle(4);

    // D=4: back-to-back burst, then sparse pattern.
    peak = 0;
    drive(1'b0, '0, 1'b1, 5'd4);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'(i), 1'b0, '0);
      tick();
    end
    idle(6);
    pat = 8'b1000_1101;
    for (int i = 0; i < 8; i++) begin
      drive(pat[i], 32'(100 + i), 1'b0, '0);
      tick();
    end
    idle(6);
    chk("peak_in_flight", 64'(peak), 64'd4);

    // Flush three in-flight samples with a load to the maximum delay.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(i), 1'b0, '0);
      tick();
    end
    p0 = n_pulse;
    drive(1'b1, 32'hCAFE0001, 1'b1, 5'd16);
    tick();
    chk("max_cur_delay", 64'(dif.cur_delay), 64'd16);
    chk("max_in_flight", 64'(dif.in_flight), 64'd1);
    idle(20);
    chk("max_pulses", 64'(n_pulse - p0), 64'd1);
    chk("max_data", 64'(dif.delayed_data), 64'hCAFE0001);

    // D=1 continuous stream, first sample carried with the load.
    p0 = n_pulse;
    drive(1'b1, 32'h500, 1'b1, 5'd1);
    tick();
    chk("d1_valid_first", 64'(dif.delayed_data_valid), 64'd1);
    for (int i = 1; i < 12; i++) begin
      drive(1'b1, 32'h500 + 32'(i), 1'b0, '0);
      tick();
      chk("d1_stream_data", 64'(dif.delayed_data), 64'(32'h500 + 32'(i)));
    end
    idle(3);
    chk("d1_pulses", 64'(n_pulse - p0), 64'd12);

    // Reset with three samples in flight at D=8.
    drive(1'b0, '0, 1'b1, 5'd8);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h600 + 32'(i), 1'b0, '0);
      tick();
    end
    drive(1'b0, '0, 1'b0, '0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("post_rst_data", 64'(dif.delayed_data), 64'd0);
    chk("post_rst_cur_delay", 64'(dif.cur_delay), 64'd3);
    chk("post_rst_in_flight", 64'(dif.in_flight), 64'd0);
    p0 = n_pulse;
    idle(12);
    chk("post_rst_pulses", 64'(n_pulse - p0), 64'd0);

    // Operation resumes at the reset delay.
    drive(1'b1, 32'h7777, 1'b0, '0);
    tick();
    idle(5);
    chk("resume_data", 64'(dif.delayed_data), 64'h7777);
    chk("drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
